err_calc: RTL and testbench

ERR_CALC -- requirements
Module: err_calc

---
 rtl/err_calc_if.sv | 27 ++
 rtl/err_calc.sv | 141 ++++++++++++++
 tb/tb_err_calc.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/err_calc_if.sv
// Loader-side bus of the residual calculator. The loader drives the sample stream and the
// coefficients, and the calculator returns residuals and the run status.
interface err_calc_if #(
  parameter int unsigned W = 20
);
  logic         en_err;
  logic [W-1:0] inx;
  logic [W-1:0] iny;
  logic         cout;
  logic [W-1:0] b0;
  logic [W-1:0] b1;
  logic [W-1:0] err_out;
  logic         err_valid;
  logic         err_done;
  logic [7:0]   err_cnt;
  logic [27:0]  abs_sum;

  modport master (
    output en_err, inx, iny, cout, b0, b1,
    input  err_out, err_valid, err_done, err_cnt, abs_sum
  );

  modport slave (
    input  en_err, inx, iny, cout, b0, b1,
    output err_out, err_valid, err_done, err_cnt, abs_sum
  );
endinterface

// File: rtl/err_calc.sv
// Residual calculator: err = y - (b0 + b1*x) in signed Q10.10 for each streamed sample,
// with a two-stage pipeline, a saturating sum of |err| and a done pulse back to the loader.
module err_calc #(
  parameter int unsigned W    = 20,
  parameter int unsigned FRAC = 10
) (
  input logic       clk,
  input logic       rst,
  err_calc_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StRun, StDrain1, StDrain2, StDone, StWaitLow
  } state_e;

  localparam int unsigned SumW = 28;
  localparam logic signed [W+1:0] ResMax = (W+2)'((1 << (W-1)) - 1);
  localparam logic signed [W+1:0] ResMin = ~ResMax;
  localparam logic [SumW-1:0] SumMax = '1;

  state_e              state_q;
  logic                done_q;
  logic signed [W-1:0] b0_q, b1_q;
  logic signed [W-1:0] y1_q, prod_q;
  logic                v1_q;
  logic signed [W-1:0] out_q;
  logic                valid_q;
  logic [7:0]          cnt_q;
  logic [SumW-1:0]     sum_q;

  logic                  accept, start;
  logic signed [W-1:0]   b1_sel;
  logic signed [2*W-1:0] b1_ext, x_ext;
  logic signed [W+1:0]   res;
  logic signed [W-1:0]   res_sat;
  logic [W-1:0]          res_abs;
  logic [SumW:0]         sum_ext;

  // Sample acceptance and run start decode.
  always_comb begin
    accept = bus.en_err && (state_q == StIdle || state_q == StRun);
    start  = bus.en_err && (state_q == StIdle);
  end

  // Residual datapath: coefficient select, widened subtraction, saturation, magnitude, sum.
  always_comb begin
    // The first sample of a run multiplies by the coefficient being latched in the same cycle.
    b1_sel = (state_q == StIdle) ? $signed(bus.b1) : b1_q;
    b1_ext = {{W{b1_sel[W-1]}}, b1_sel};
    x_ext  = {{W{bus.inx[W-1]}}, bus.inx};
    res    = {{2{y1_q[W-1]}}, y1_q} - {{2{b0_q[W-1]}}, b0_q} - {{2{prod_q[W-1]}}, prod_q};
    if (res > ResMax) begin
      res_sat = ResMax[W-1:0];
    end else if (res < ResMin) begin
      res_sat = ResMin[W-1:0];
    end else begin
      res_sat = res[W-1:0];
    end
    // Unsigned W bits hold 2^(W-1), so the most negative residual has an exact magnitude.
    res_abs = res_sat[W-1] ? (~res_sat + 1'b1) : res_sat;
    sum_ext = {1'b0, sum_q} + {{(SumW+1-W){1'b0}}, res_abs};
  end

  // Run control FSM with registered done pulse and coefficient holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      b0_q    <= '0;
      b1_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            b0_q    <= $signed(bus.b0);
            b1_q    <= $signed(bus.b1);
            state_q <= bus.cout ? StDrain1 : StRun;
          end
        end
        StRun: begin
          if (!bus.en_err) begin
            state_q <= StIdle;
          end else if (bus.cout) begin
            state_q <= StDrain1;
          end
        end
        StDrain1: state_q <= StDrain2;
        StDrain2: begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StDone:   state_q <= StWaitLow;
        StWaitLow: begin
          if (!bus.en_err) begin
            state_q <= StIdle;
          end
        end
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Two-stage pipeline plus residual count and saturating magnitude sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      y1_q    <= '0;
      prod_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      // An abort stops new samples entering; the sample already in stage 1 still completes.
      v1_q    <= accept;
      valid_q <= v1_q;
      if (accept) begin
        y1_q   <= $signed(bus.iny);
        // Only the Q10.10 integer-aligned slice of the product feeds the residual.
        prod_q <= W'((b1_ext * x_ext) >>> FRAC);
      end
      if (v1_q) begin
        out_q <= res_sat;
        cnt_q <= cnt_q + 8'd1;
        sum_q <= sum_ext[SumW] ? SumMax : sum_ext[SumW-1:0];
      end
      if (start) begin
        cnt_q <= '0;
        sum_q <= '0;
      end
    end
  end

  assign bus.err_out   = out_q;
  assign bus.err_valid = valid_q;
  assign bus.err_done  = done_q;
  assign bus.err_cnt   = cnt_q;
  assign bus.abs_sum   = sum_q;

endmodule

// File: tb/tb_err_calc.sv
// Scoreboard bench for err_calc: the driver pushes expected residuals/done cycles computed
// with plain integer arithmetic; a negedge monitor pops and compares whenever the DUT responds.
module tb_err_calc;
  localparam int W = 20;
  localparam int SumMax = 268435455;

  typedef struct {
    int          cyc;
    logic [19:0] out;
    int          cnt;
    int          sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  err_calc_if #(.W(W)) bus();
  err_calc #(.W(W), .FRAC(10)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t        exp_q[$];
  int          done_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [19:0] last_out = '0;
  bit          mon_on = 1'b0;
  int          m_cnt, m_sum;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: y - b0 - trunc20(floor(b1*x / 2^10)), clamped to the signed 20-bit range.
  function automatic logic [19:0] ref_res(input logic [19:0] c0, c1, x, y);
    longint b0s, b1s, xs, ys, t, r;
    b0s = longint'($signed(c0));
    b1s = longint'($signed(c1));
    xs  = longint'($signed(x));
    ys  = longint'($signed(y));
    t = (b1s * xs) >>> 10;
    t = t & 64'hFFFFF;
    if (t >= 524288) t = t - 1048576;
    r = ys - b0s - t;
    if (r > 524287) r = 524287;
    if (r < -524288) r = -524288;
    return r[19:0];
  endfunction

  function automatic logic [19:0] rnd20();
    case ($urandom_range(0, 7))
      0:       return 20'h7FFFF;
      1:       return 20'h80000;
      2, 3:    return 20'(int'($urandom_range(0, 65535)) - 32768);
      default: return 20'($urandom);
    endcase
  endfunction

  // Monitor: compare each presented residual / done pulse against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_on) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL missed_valid: actual none required at cycle %0d", exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL missed_done: actual none required at cycle %0d", done_q[0]);
        void'(done_q.pop_front());
      end
      if (bus.err_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_valid: actual 1 required 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("valid_cycle", 64'(cyc), 64'(e.cyc));
          check("err_out", 64'(bus.err_out), 64'(e.out));
          check("err_cnt", 64'(bus.err_cnt), 64'(e.cnt));
          check("abs_sum", 64'(bus.abs_sum), 64'(e.sum));
          last_out = e.out;
        end
      end else begin
        check("err_out_hold", 64'(bus.err_out), 64'(last_out));
      end
      if (bus.err_done === 1'b1) begin
        if (done_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: actual 1 required 0 (cycle %0d)", cyc);
        end else begin
          check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        end
      end
    end
  end

  task automatic send(input logic [19:0] x, y, input bit first, last,
                      input logic [19:0] c0, c1);
    logic [19:0] r;
    int a;
    bus.en_err = 1'b1;
    bus.inx    = x;
    bus.iny    = y;
    bus.cout   = last;
    if (first) begin
      bus.b0 = c0;
      bus.b1 = c1;
    end else begin
      // Coefficient inputs wander mid-run; the run must keep its latched values.
      bus.b0 = 20'($urandom);
      bus.b1 = 20'($urandom);
    end
    r = ref_res(c0, c1, x, y);
    a = int'($signed(r));
    if (a < 0) a = -a;
    m_cnt = (m_cnt + 1) % 256;
    m_sum = m_sum + a;
    if (m_sum > SumMax) m_sum = SumMax;
    exp_q.push_back('{cyc + 2, r, m_cnt, m_sum});
    if (last) done_q.push_back(cyc + 3);
    @(posedge clk);
    #1;
  endtask

  // One run of n samples; stop_at >= 0 cuts it short by dropping en_err or, with with_rst,
  // by asserting reset; hold keeps en_err high that many cycles after the last sample.
  task automatic do_run(input int n, input logic [19:0] c0, c1, input bit fixed,
                        input logic [19:0] fx, fy, input int stop_at, input bit with_rst,
                        input int hold);
    logic [19:0] x, y;
    m_cnt = 0;
    m_sum = 0;
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) break;
      x = fixed ? fx : rnd20();
      y = fixed ? fy : rnd20();
      send(x, y, i == 0, i == n - 1, c0, c1);
    end
    if (with_rst) begin
      rst        = 1'b1;
      bus.en_err = 1'b0;
      bus.cout   = 1'b0;
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
      done_q.delete();
      @(posedge clk);
      #1;
      last_out = '0;
      @(negedge clk);
      check("rst_err_out", 64'(bus.err_out), 64'd0);
      check("rst_err_valid", 64'(bus.err_valid), 64'd0);
      check("rst_err_done", 64'(bus.err_done), 64'd0);
      check("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
      check("rst_abs_sum", 64'(bus.abs_sum), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
    end else if (hold > 0) begin
      repeat (hold) begin
        bus.inx  = rnd20();
        bus.iny  = rnd20();
        bus.cout = 1'($urandom);
        @(posedge clk);
        #1;
      end
    end
    bus.en_err = 1'b0;
    bus.cout   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "bench timed out");
  end

  initial begin : driver
    logic [19:0] c0, c1;
    bus.en_err = 1'b0;
    bus.inx    = '0;
    bus.iny    = '0;
    bus.cout   = 1'b0;
    bus.b0     = '0;
    bus.b1     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("init_err_out", 64'(bus.err_out), 64'd0);
    check("init_err_valid", 64'(bus.err_valid), 64'd0);
    check("init_err_done", 64'(bus.err_done), 64'd0);
    check("init_err_cnt", 64'(bus.err_cnt), 64'd0);
    check("init_abs_sum", 64'(bus.abs_sum), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_on = 1'b1;

    // Identity fit, then a single exact sample, then both saturation corners.
    do_run(4, 20'h00000, 20'h00400, 1'b1, 20'h00C00, 20'h00C00, -1, 1'b0, 0);
    do_run(1, 20'h00400, 20'h00800, 1'b1, 20'h00400, 20'h01400, -1, 1'b0, 0);
    do_run(1, 20'hFFC00, 20'h00000, 1'b1, 20'h12345, 20'h7FFFF, -1, 1'b0, 0);
    do_run(1, 20'h00400, 20'h00000, 1'b1, 20'h00000, 20'h80000, -1, 1'b0, 0);

    // Abort after 3 of 10, then a clean run whose count restarts.
    do_run(10, rnd20(), 20'h00C00, 1'b0, '0, '0, 3, 1'b0, 0);
    do_run(5, rnd20(), 20'hFF800, 1'b0, '0, '0, -1, 1'b0, 0);

    // Enable held past the done pulse must not retrigger.
    do_run(6, rnd20(), 20'h00200, 1'b0, '0, '0, -1, 1'b0, 5);
    do_run(3, rnd20(), 20'h00600, 1'b0, '0, '0, -1, 1'b0, 0);

    for (int k = 0; k < 8; k++) begin
      c0 = rnd20();
      c1 = 20'(int'($urandom_range(0, 16383)) - 8192);
      do_run(int'($urandom_range(1, 20)), c0, c1, 1'b0, '0, '0, -1, 1'b0, 0);
    end

    // Long run of maximal residuals: count wraps past 255 and the sum saturates.
    do_run(600, 20'hFFC00, 20'h00000, 1'b1, 20'h00000, 20'h7FFFF, -1, 1'b0, 0);

    // Reset in the middle of a 150-sample run, then a normal run.
    do_run(150, rnd20(), 20'h00300, 1'b0, '0, '0, 80, 1'b1, 0);
    do_run(4, rnd20(), 20'h00500, 1'b0, '0, '0, -1, 1'b0, 0);

    repeat (5) @(posedge clk);
    #1;
    check("pending_valids", 64'(exp_q.size()), 64'd0);
    check("pending_done", 64'(done_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
